// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter sharing one FIFO write port among NREQ producers.
// Optional full-stall counter enabled with FIFO_ARB_STALL_CNT_EN.
module fifo_wr_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 32,
  parameter int BURST_MAX = 4,
  localparam int OW       = $clog2(NREQ)
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] data_in,
  output logic [NREQ-1:0]   gnt,
  input  logic              fifo_full,
  output logic              fifo_wr,
  output logic [DW-1:0]     fifo_data,
  output logic [OW-1:0]     owner,
  output logic              busy,
  output logic [15:0]       stall_cnt
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [OW-1:0] ptr;
  logic [7:0]    bcnt;
  logic [OW-1:0] pick;
  logic          found;
  logic [OW-1:0] nxt_ptr;
  logic          own_req;
  logic          last;
  int            j;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    j     = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!found && req[j[OW-1:0]]) begin
        found = 1'b1;
        pick  = j[OW-1:0];
      end
    end
  end

  always_comb begin
    fifo_data = data_in[DW-1:0];
    for (int i = 0; i < NREQ; i++)
      if (owner == OW'(i)) fifo_data = data_in[i*DW +: DW];
  end

  assign own_req = req[owner];
  assign busy    = (state == GRANT);
  // Reset in the same cycle suppresses the write so the edge commits nothing.
  assign fifo_wr = busy & own_req & ~fifo_full & Rst;
  assign last    = ((bcnt + 8'd1) == 8'(BURST_MAX));
  assign nxt_ptr = (owner == OW'(NREQ-1)) ? '0 : owner + 1'b1;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state <= IDLE;
      gnt   <= '0;
      ptr   <= '0;
      owner <= '0;
      bcnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            owner <= pick;
            gnt   <= NREQ'(1) << pick;
            bcnt  <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (!own_req || (!fifo_full && last)) begin
            state <= IDLE;
            gnt   <= '0;
            ptr   <= nxt_ptr;
            bcnt  <= '0;
          end else if (!fifo_full) begin
            bcnt <= bcnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_ARB_STALL_CNT_EN
  always_ff @(posedge Clk) begin
    if (!Rst)
      stall_cnt <= '0;
    else if (busy && own_req && fifo_full && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`else
  assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: two instances, BURST_MAX 4 and 2.
module tb_fifo_wr_arbiter;

  logic         Clk = 1'b0;
  logic         Rst;
  logic [3:0]   req;
  logic [127:0] data_in;
  logic         fifo_full;

  logic [3:0]  a_gnt, b_gnt;
  logic        a_wr, b_wr, a_busy, b_busy;
  logic [31:0] a_data, b_data;
  logic [1:0]  a_owner, b_owner;
  logic [15:0] a_stall, b_stall;

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  fifo_wr_arbiter #(.NREQ(4), .DW(32), .BURST_MAX(4)) u4 (
    .Clk(Clk), .Rst(Rst), .req(req), .data_in(data_in),
    .gnt(a_gnt), .fifo_full(fifo_full), .fifo_wr(a_wr),
    .fifo_data(a_data), .owner(a_owner), .busy(a_busy),
    .stall_cnt(a_stall)
  );

  fifo_wr_arbiter #(.NREQ(4), .DW(32), .BURST_MAX(2)) u2 (
    .Clk(Clk), .Rst(Rst), .req(req), .data_in(data_in),
    .gnt(b_gnt), .fifo_full(fifo_full), .fifo_wr(b_wr),
    .fifo_data(b_data), .owner(b_owner), .busy(b_busy),
    .stall_cnt(b_stall)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic lanes_default();
    for (int i = 0; i < 4; i++) data_in[i*32 +: 32] = 32'hA0 + i;
  endtask

  task automatic do_reset();
    Rst = 1'b0;
    req = '0;
    fifo_full = 1'b0;
    lanes_default();
    tick();
    Rst = 1'b1;
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    req = 4'hF;
    fifo_full = 1'b0;
    lanes_default();
    for (int c = 0; c < 3; c++) begin
      tick();
      tests++;
      if ({a_gnt, a_wr, a_busy} !== 6'b0 || a_stall !== 16'h0) begin
        fails++;
        $display("FAIL reset_hold c%0d: gnt=%b wr=%b busy=%b stall=%h want 0",
                 c, a_gnt, a_wr, a_busy, a_stall);
      end
      tests++;
      if (a_data !== 32'hA0) begin
        fails++;
        $display("FAIL reset_data: got %h want %h", a_data, 32'hA0);
      end
    end
    Rst = 1'b1;
    tick();
    tests++;
    if (a_gnt !== 4'b0001 || a_owner !== 2'd0) begin
      fails++;
      $display("FAIL reset_first_gnt: gnt=%b owner=%0d want 0001/0", a_gnt, a_owner);
    end
  endtask

  task automatic test_single_burst();
    do_reset();
    req = 4'b0100;
    data_in[64 +: 32] = 32'd1;
    tick();
    for (int k = 1; k <= 4; k++) begin
      tests++;
      if (a_gnt !== 4'b0100 || a_wr !== 1'b1 || a_data !== 32'(k)) begin
        fails++;
        $display("FAIL burst_w%0d: gnt=%b wr=%b data=%0d want 0100/1/%0d",
                 k, a_gnt, a_wr, a_data, k);
      end
      data_in[64 +: 32] = 32'(k + 1);
      tick();
    end
    tests++;
    if ({a_gnt, a_wr, a_busy} !== 6'b0) begin
      fails++;
      $display("FAIL burst_dead: gnt=%b wr=%b busy=%b want 0", a_gnt, a_wr, a_busy);
    end
    tick();
    tests++;
    if (a_gnt !== 4'b0100 || a_wr !== 1'b1 || a_data !== 32'd5) begin
      fails++;
      $display("FAIL burst_regrant: gnt=%b wr=%b data=%0d want 0100/1/5",
               a_gnt, a_wr, a_data);
    end
    req = '0;
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    req = 4'hF;
    tick();
    for (int n = 0; n < 5; n++) begin
      for (int w = 0; w < 2; w++) begin
        tests++;
        if (b_gnt !== (4'b0001 << order[n]) || b_wr !== 1'b1 ||
            b_owner !== 2'(order[n]) || b_data !== 32'hA0 + order[n]) begin
          fails++;
          $display("FAIL rr_g%0d_w%0d: gnt=%b wr=%b owner=%0d data=%h want owner %0d",
                   n, w, b_gnt, b_wr, b_owner, b_data, order[n]);
        end
        tick();
      end
      tests++;
      if (b_gnt !== 4'b0 || b_wr !== 1'b0) begin
        fails++;
        $display("FAIL rr_dead%0d: gnt=%b wr=%b want 0000/0", n, b_gnt, b_wr);
      end
      tick();
    end
    req = '0;
  endtask

  task automatic test_back_pressure();
    logic [15:0] exp_stall;
`ifdef FIFO_ARB_STALL_CNT_EN
    exp_stall = 16'd3;
`else
    exp_stall = 16'd0;
`endif
    do_reset();
    req = 4'b0010;
    tick();
    tests++;
    if (a_gnt !== 4'b0010 || a_wr !== 1'b1) begin
      fails++;
      $display("FAIL bp_first: gnt=%b wr=%b want 0010/1", a_gnt, a_wr);
    end
    tick();
    fifo_full = 1'b1;
    for (int s = 0; s < 3; s++) begin
      #1;
      tests++;
      if (a_gnt !== 4'b0010 || a_wr !== 1'b0) begin
        fails++;
        $display("FAIL bp_stall%0d: gnt=%b wr=%b want 0010/0", s, a_gnt, a_wr);
      end
      tick();
    end
    fifo_full = 1'b0;
    #1;
    tests++;
    if (a_stall !== exp_stall || a_wr !== 1'b1) begin
      fails++;
      $display("FAIL bp_resume: stall=%0d wr=%b want %0d/1", a_stall, a_wr, exp_stall);
    end
    for (int w = 0; w < 2; w++) begin
      tick();
      tests++;
      if (a_gnt !== 4'b0010 || a_wr !== 1'b1) begin
        fails++;
        $display("FAIL bp_tail%0d: gnt=%b wr=%b want 0010/1", w, a_gnt, a_wr);
      end
    end
    tick();
    tests++;
    if (a_gnt !== 4'b0 || a_busy !== 1'b0) begin
      fails++;
      $display("FAIL bp_release: gnt=%b busy=%b want 0000/0", a_gnt, a_busy);
    end
    req = '0;
  endtask

  task automatic test_early_drop();
    do_reset();
    req = 4'b1000;
    tick();
    tests++;
    if (a_gnt !== 4'b1000 || a_wr !== 1'b1) begin
      fails++;
      $display("FAIL drop_gnt: gnt=%b wr=%b want 1000/1", a_gnt, a_wr);
    end
    tick();
    req = 4'b0101;
    #1;
    tests++;
    if (a_wr !== 1'b0 || a_gnt !== 4'b1000) begin
      fails++;
      $display("FAIL drop_nowr: gnt=%b wr=%b want 1000/0", a_gnt, a_wr);
    end
    tick();
    tests++;
    if (a_gnt !== 4'b0 || a_busy !== 1'b0) begin
      fails++;
      $display("FAIL drop_release: gnt=%b busy=%b want 0000/0", a_gnt, a_busy);
    end
    tick();
    tests++;
    if (a_gnt !== 4'b0001 || a_owner !== 2'd0) begin
      fails++;
      $display("FAIL drop_next: gnt=%b owner=%0d want 0001/0", a_gnt, a_owner);
    end
    req = '0;
  endtask

  task automatic test_mid_reset();
    do_reset();
    req = 4'b0100;
    tick();
    tests++;
    if (a_wr !== 1'b1) begin
      fails++;
      $display("FAIL mrst_first: wr=%b want 1", a_wr);
    end
    tick();
    Rst = 1'b0;
    #1;
    tests++;
    if (a_wr !== 1'b0) begin
      fails++;
      $display("FAIL mrst_nowr: wr=%b want 0", a_wr);
    end
    tick();
    Rst = 1'b1;
    req = 4'b1100;
    #1;
    tests++;
    if (a_gnt !== 4'b0 || a_busy !== 1'b0) begin
      fails++;
      $display("FAIL mrst_idle: gnt=%b busy=%b want 0000/0", a_gnt, a_busy);
    end
    tick();
    tests++;
    if (a_gnt !== 4'b0100 || a_owner !== 2'd2) begin
      fails++;
      $display("FAIL mrst_ptr: gnt=%b owner=%0d want 0100/2", a_gnt, a_owner);
    end
    req = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_back_pressure();
    test_early_drop();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

- Round-robin write arbiter that shares one `fifo_n` write port (`WR`/`dataIn`, back-pressured by `FULL`) among `NREQ` producers.
- Grants one requester at a time and holds the grant for a bounded burst.
- Forwards that requester's data combinationally into the FIFO and rotates priority after every grant.
- Sits between producer blocks and the FIFO write side; the FIFO read side is untouched.

## Interface
- `NREQ`, default 4: number of requesters (2..8).
- `DW`, default 32: data width; matches the FIFO `dataIn`.
- `BURST_MAX`, default 4: maximum transfers per grant (1..255).
- `Clk`  input  1: clock; all state updates on the rising edge.
- `Rst`  input  1: reset. One clock; reset is synchronous and active-low.
- `req`  input  NREQ: per-requester write request; held high while the requester has data.
- `data_in`  input  NREQ*DW: flattened requester data; requester i occupies bits [i*DW +: DW].
- `gnt`  output  NREQ: one-hot registered grant.
- `fifo_full`  input  1: connects to FIFO `FULL`.
- `fifo_wr`  output  1: connects to FIFO `WR`.
- `fifo_data`  output  DW: connects to FIFO `dataIn`.
- `owner`  output  $clog2(NREQ): index of the current or last grantee.
- `busy`  output  1: high while in GRANT.
- `stall_cnt`  output  16: count of full-stall cycles (see Configuration).

## Operation
- **Registered state:** `state` (IDLE/GRANT), `ptr` (round-robin start index), `owner`, 8-bit `bcnt`, `gnt`, `stall_cnt`.
- **Reset** (`Rst`=0 at an edge): `state`=IDLE, `gnt`=0, `ptr`=0, `owner`=0, `bcnt`=0, `stall_cnt`=0.
  - Consequently `fifo_wr`=0, `busy`=0, and `fifo_data` = requester 0's data.
  - Reset overrides everything, including a transfer pending in the same cycle.
  - A burst interrupted by reset is abandoned; no FIFO write occurs on that edge.
- **IDLE:**
  - If `req`≠0, select the first i with `req[i]`=1, scanning `ptr`, `ptr`+1, … modulo NREQ.
  - Next state: `owner`=i, `gnt`=one-hot(i), `bcnt`=0, state→GRANT.
  - If `req`=0, remain in IDLE.
- **GRANT:**
  - `xfer` = `req[owner]` & ~`fifo_full`.
  - `fifo_wr` = `xfer` (combinational).
  - `fifo_data` = `data_in[owner]` (combinational mux, always driven).
  - On `xfer`: `bcnt`+1. If `bcnt`+1 == BURST_MAX, release.
  - If `req[owner]`=0: release with no transfer.
  - If `req[owner]`=1 and `fifo_full`=1: stall. Grant held, `bcnt` held, no write.
- **Release:** state→IDLE, `gnt`→0, `ptr`→(`owner`+1) mod NREQ, `bcnt`→0.
- **Fairness:** with all requesters active, grants rotate 0,1,…,NREQ-1,0,…
- **Counter width:** `bcnt` is 8 bits; BURST_MAX ≤ 255, so it never wraps.
- **Full and drop in the same cycle:** if `fifo_full`=1 and `req[owner]` drops together, release with no write.
- **Non-owner requests:** changes in non-owner `req` bits during GRANT are ignored until the next IDLE.
- **Requester obligation:** present the next word on every cycle in which it sees `gnt`=1, `req`=1 and `fifo_full`=0.

## Timing
- **Grant latency:** `req` high at edge k (in IDLE) → `gnt` high after edge k; first possible write on cycle k+1.
- **Dead cycle:** one IDLE cycle always separates consecutive grants.
  - Peak throughput is BURST_MAX/(BURST_MAX+1) writes per cycle.
- **FULL:** sampled in the same cycle as `fifo_wr` is generated, so no write is ever issued while `fifo_full`=1.
- **Release timing:** `gnt` falls on the edge after the last transfer.
  - The grantee must treat `gnt`&`req`&~`fifo_full` as the accept strobe.

## Configuration
- Macro: `FIFO_ARB_STALL_CNT_EN`.
- **Defined:** `stall_cnt` increments by 1 on every GRANT cycle with `req[owner]`=1 and `fifo_full`=1.
  - Saturates at 16'hFFFF.
  - Clears only on reset.
- **Undefined:** no counter logic; `stall_cnt` is tied to 16'h0000. All other behaviour is identical.

## Test plan
- **Reset:** hold `Rst`=0 for 3 cycles with `req`=4'b1111. Expect `gnt`=0, `fifo_wr`=0, `busy`=0 and `stall_cnt`=0 throughout; first grant goes to requester 0 one edge after `Rst`=1.
- **Single burst:** NREQ=4, BURST_MAX=4; requester 2 holds `req` with data 1,2,3,4,5; `fifo_full`=0. Expect 4 writes of 1..4, then `gnt` falls, 1 IDLE cycle, regrant to 2, and a write of 5.
- **Round-robin:** `req`=4'b1111 held; BURST_MAX=2. Expect grant order 0,1,2,3,0; 2 writes each; exactly one `gnt`=0 cycle between grants.
- **Back-pressure:**
  - Requester 1 granted; `fifo_full`=1 for 3 cycles mid-burst. Expect `fifo_wr`=0 on those cycles, grant and `bcnt` held, burst resumes after.
  - With the macro defined, expect `stall_cnt`=3; without it, `stall_cnt`=0.
- **Early drop:** requester 3 granted; `req[3]` drops after 1 write with BURST_MAX=4. Expect release; `ptr`=0 so a pending `req[0]` wins next.
- **Mid-burst reset:** assert `Rst`=0 during the 2nd transfer. Expect no write that cycle, `gnt`=0 and `ptr`=0 afterwards.
